// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : snake_pkg
//  Description : Shared types and helpers for the snake game-flow core:
//                heading and game-mode enums, the turn token stored in the
//                per-player queues, and the heading rotation/reset helpers.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } direction;

    typedef enum logic [1:0] {
        MENU = 2'd0,
        GAME = 2'd1,
        OVER = 2'd2
    } game_mode;

    // One queued turn: 0 = turn left, 1 = turn right
    typedef logic turn_t;

    localparam turn_t TURN_LEFT  = 1'b0;
    localparam turn_t TURN_RIGHT = 1'b1;

    // Clockwise step through UP -> RIGHT -> DOWN -> LEFT -> UP
    function automatic direction rot_cw(input direction d);
        case (d)
            UP:      return RIGHT;
            RIGHT:   return DOWN;
            DOWN:    return LEFT;
            default: return UP;
        endcase
    endfunction

    // Counter-clockwise step through UP -> LEFT -> DOWN -> RIGHT -> UP
    function automatic direction rot_ccw(input direction d);
        case (d)
            UP:      return LEFT;
            LEFT:    return DOWN;
            DOWN:    return RIGHT;
            default: return UP;
        endcase
    endfunction

    // Starting heading: even players face right, odd players face left
    function automatic direction reset_dir(input int idx);
        return ((idx % 2) == 0) ? RIGHT : LEFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/turn_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : turn_fifo
//  Description : Small circular queue of turn tokens for one player.
//                A pop on an empty queue is ignored; a push on a full queue
//                is accepted only when a pop happens in the same cycle.
//                No bypass: a word pushed into an empty queue becomes visible
//                on dout only after the push edge.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                push, din         enqueue request and token
//                pop               dequeue request
//                flush             empty the queue (same effect as rst)
//                dout              head-of-queue token
//                empty, full       occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module turn_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  logic  flush,
    input  turn_t din,
    output turn_t dout,
    output logic  empty,
    output logic  full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] C_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(DEPTH);

    turn_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_occ;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_occ == '0);
    assign full      = (r_occ == C_DEPTH);
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // When full, the slot being popped is the slot being written, so the
    // simultaneous push is safe.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push && !rst && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Game-flow core for N-player snake. Runs the MENU/GAME/OVER
//                mode machine, a move-tick generator whose period shrinks as
//                points are eaten, and one turn queue per player so that
//                rapid turn requests are applied one per move tick.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                start           MENU->GAME, OVER->MENU pulse
//                left, right     per-player turn pulses
//                point_eaten     speeds up the move tick
//                collision       per-player collision flags
//                mode            current game mode
//                tick            one-cycle move strobe
//                dir             per-player heading
//                winner          ~collision latched at game end
//                overflow        sticky per-player dropped-turn flag
//  Revision    : 1.0  initial release
// ============================================================================
module game_sequencer
    import snake_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int TURN_DEPTH = 4,
    parameter int TICK_START = 7_500_000,
    parameter int TICK_MIN   = 1_875_000,
    parameter int TICK_STEP  = 375_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_PLAYERS-1:0] left,
    input  logic [N_PLAYERS-1:0] right,
    input  logic                 point_eaten,
    input  logic [N_PLAYERS-1:0] collision,
    output game_mode             mode,
    output logic                 tick,
    output direction             dir [N_PLAYERS],
    output logic [N_PLAYERS-1:0] winner,
    output logic [N_PLAYERS-1:0] overflow
);

    localparam int CNT_W = $clog2(TICK_START + 1);

    localparam logic [CNT_W-1:0] C_TICK_START = CNT_W'(TICK_START);
    localparam logic [CNT_W-1:0] C_TICK_MIN   = CNT_W'(TICK_MIN);
    localparam logic [CNT_W-1:0] C_TICK_STEP  = CNT_W'(TICK_STEP);

    game_mode               r_state;
    game_mode               w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       w_period_sub;
    logic [CNT_W-1:0]       w_period_dec;
    logic                   r_tick;
    logic [N_PLAYERS-1:0]   r_winner;
    logic                   w_in_game;
    logic                   w_enter_game;
    logic                   w_tick_fire;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MENU;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MENU:    if (start)      w_next_state = GAME;
            GAME:    if (|collision) w_next_state = OVER;
            OVER:    if (start)      w_next_state = MENU;
            default:                 w_next_state = MENU;
        endcase
    end

    always_comb begin
        mode         = r_state;
        w_in_game    = (r_state == GAME);
        w_enter_game = (r_state == MENU) && start;
        // A collision ends the game on this edge, so its tick is dropped
        w_tick_fire  = w_in_game && (r_cnt == '0) && !(|collision);
    end

    // ------------------------------------------------------ tick generator
    // Unsigned decrement with a floor: never wraps below TICK_MIN
    assign w_period_sub = r_period - C_TICK_STEP;
    assign w_period_dec = ((r_period >= C_TICK_STEP) && (w_period_sub >= C_TICK_MIN))
                          ? w_period_sub : C_TICK_MIN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= C_TICK_START;
            r_cnt    <= C_TICK_START - CNT_W'(1);
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_tick_fire;
            if (w_enter_game) begin
                r_period <= C_TICK_START;
                r_cnt    <= C_TICK_START - CNT_W'(1);
            end else if (w_in_game) begin
                if (point_eaten) begin
                    r_period <= w_period_dec;
                end
                // Reload uses the period as it stood before this cycle's
                // point_eaten, so a speed-up applies from the next reload on
                r_cnt <= (r_cnt == '0) ? r_period - CNT_W'(1) : r_cnt - CNT_W'(1);
            end
        end
    end

    assign tick = r_tick;

    // -------------------------------------------------------------- winner
    always_ff @(posedge clk) begin
        if (rst) begin
            r_winner <= '0;
        end else if (w_in_game && (|collision)) begin
            r_winner <= ~collision;
        end
    end

    assign winner = r_winner;

    // ---------------------------------------------------- per-player turns
    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
        logic     w_push;
        logic     w_pop;
        turn_t    w_head;
        logic     w_empty;
        logic     w_full;
        direction r_hdg;
        logic     r_ovf;

        // Simultaneous left and right cancel out
        assign w_push = w_in_game && (left[gi] ^ right[gi]);
        assign w_pop  = w_tick_fire && !w_empty;

        turn_fifo #(
            .DEPTH (TURN_DEPTH)
        ) u_turn_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push),
            .pop   (w_pop),
            .flush (w_enter_game),
            .din   (right[gi]),
            .dout  (w_head),
            .empty (w_empty),
            .full  (w_full)
        );

        always_ff @(posedge clk) begin
            if (rst || w_enter_game) begin
                r_hdg <= reset_dir(gi);
                r_ovf <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_hdg <= (w_head == TURN_RIGHT) ? rot_cw(r_hdg) : rot_ccw(r_hdg);
                end
                if (w_push && w_full && !w_pop) begin
                    r_ovf <= 1'b1;
                end
            end
        end

        assign dir[gi]      = r_hdg;
        assign overflow[gi] = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Self-checking bench for game_sequencer. Directed scenarios
//                followed by a randomized run; every cycle the DUT outputs
//                are compared with a queue-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_sequencer;
    import snake_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 2;
    localparam int TS    = 10;
    localparam int TMIN  = 4;
    localparam int TSTEP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NP-1:0] left;
    logic [NP-1:0] right;
    logic          point_eaten;
    logic [NP-1:0] collision;
    game_mode      mode;
    logic          tick;
    direction      dir [NP];
    logic [NP-1:0] winner;
    logic [NP-1:0] overflow;

    game_sequencer #(
        .N_PLAYERS  (NP),
        .TURN_DEPTH (DEPTH),
        .TICK_START (TS),
        .TICK_MIN   (TMIN),
        .TICK_STEP  (TSTEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .left        (left),
        .right       (right),
        .point_eaten (point_eaten),
        .collision   (collision),
        .mode        (mode),
        .tick        (tick),
        .dir         (dir),
        .winner      (winner),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------------------------------------------- reference model
    int       m_mode;        // 0 MENU, 1 GAME, 2 OVER
    int       m_wait;        // edges remaining until the next move
    int       m_period;
    int       m_dir [NP];    // 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
    bit [1:0] m_ovf;
    bit [1:0] m_win;
    bit       m_tick;
    bit       mq [NP][$];

    // observation bookkeeping
    int       cyc = 0;
    int       last_tick_cyc = 0;
    int       last_spacing = 0;
    int       n_ticks = 0;
    bit       tick_now = 0;
    game_mode prev_mode = MENU;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_start_game();
        m_mode   = 1;
        m_period = TS;
        m_wait   = TS;
        m_ovf    = '0;
        for (int p = 0; p < NP; p++) begin
            m_dir[p] = (p % 2 == 0) ? 1 : 3;
            mq[p].delete();
        end
    endtask

    task automatic model_reset();
        model_start_game();
        m_mode = 0;
        m_tick = 0;
        m_win  = '0;
    endtask

    task automatic model_step(input bit i_rst, input bit i_st, input bit [1:0] i_l,
                              input bit [1:0] i_r, input bit i_pe, input bit [1:0] i_col);
        bit fire;
        m_tick = 0;
        if (i_rst) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (i_st) model_start_game();
            1: begin
                fire   = 0;
                m_wait = m_wait - 1;
                if (m_wait == 0) begin
                    m_wait = m_period;
                    fire   = (i_col == 0);
                end
                if (i_pe) m_period = (m_period - TSTEP < TMIN) ? TMIN : m_period - TSTEP;
                for (int p = 0; p < NP; p++) begin
                    if (fire && mq[p].size() > 0) begin
                        if (mq[p].pop_front()) m_dir[p] = (m_dir[p] + 1) % 4;
                        else                   m_dir[p] = (m_dir[p] + 3) % 4;
                    end
                    if (i_l[p] ^ i_r[p]) begin
                        if (mq[p].size() < DEPTH) mq[p].push_back(i_r[p]);
                        else                      m_ovf[p] = 1'b1;
                    end
                end
                m_tick = fire;
                if (i_col != 0) begin
                    m_mode = 2;
                    m_win  = ~i_col;
                end
            end
            default: if (i_st) m_mode = 0;
        endcase
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs
    task automatic cycle(input bit i_rst, input bit i_st, input bit [1:0] i_l,
                         input bit [1:0] i_r, input bit i_pe, input bit [1:0] i_col);
        rst         = i_rst;
        start       = i_st;
        left        = i_l;
        right       = i_r;
        point_eaten = i_pe;
        collision   = i_col;
        @(posedge clk);
        model_step(i_rst, i_st, i_l, i_r, i_pe, i_col);
        #1;
        chk("mode",     32'(mode),     32'(m_mode));
        chk("tick",     32'(tick),     32'(m_tick));
        chk("dir0",     32'(dir[0]),   32'(m_dir[0]));
        chk("dir1",     32'(dir[1]),   32'(m_dir[1]));
        chk("winner",   32'(winner),   32'(m_win));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        cyc++;
        tick_now = (tick === 1'b1);
        if (mode === GAME && prev_mode !== GAME) last_tick_cyc = cyc;
        if (tick_now) begin
            last_spacing  = cyc - last_tick_cyc;
            last_tick_cyc = cyc;
            n_ticks++;
        end
        prev_mode = mode;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 2'b00, 2'b00, 0, 2'b00);
    endtask

    task automatic wait_tick(output int sp);
        bit got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle(0, 0, 2'b00, 2'b00, 0, 2'b00);
            got = tick_now;
        end
        chk("tick_wait", 32'(got), 32'd1);
        sp = last_spacing;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sp;
        int t0;
        bit [1:0] rl, rr, rc;
        rst = 1'b1; start = 1'b0; left = '0; right = '0; point_eaten = 1'b0; collision = '0;
        model_reset();

        // 1: reset, start, steady 10-cycle ticks, dirs untouched
        cycle(1, 0, 2'b00, 2'b00, 0, 2'b00);
        cycle(1, 0, 2'b00, 2'b00, 0, 2'b00);
        chk("rst_mode", 32'(mode), 32'(MENU));
        chk("rst_dir0", 32'(dir[0]), 32'(RIGHT));
        chk("rst_dir1", 32'(dir[1]), 32'(LEFT));
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        chk("start_mode", 32'(mode), 32'(GAME));
        wait_tick(sp); chk("t1_space", 32'(sp), 32'd10);
        wait_tick(sp); chk("t2_space", 32'(sp), 32'd10);
        chk("t2_dir0", 32'(dir[0]), 32'(RIGHT));
        chk("t2_dir1", 32'(dir[1]), 32'(LEFT));
        chk("t2_win", 32'(winner), 32'd0);

        // 2: P0 left,left,right with a depth-2 queue
        cycle(1, 0, 2'b00, 2'b00, 0, 2'b00);
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        cycle(0, 0, 2'b01, 2'b00, 0, 2'b00);
        cycle(0, 0, 2'b01, 2'b00, 0, 2'b00);
        cycle(0, 0, 2'b00, 2'b01, 0, 2'b00);
        chk("ovf_p0", 32'(overflow), 32'd1);
        wait_tick(sp); chk("q_tick1", 32'(dir[0]), 32'(UP));
        wait_tick(sp); chk("q_tick2", 32'(dir[0]), 32'(LEFT));
        wait_tick(sp); chk("q_tick3", 32'(dir[0]), 32'(LEFT));

        // 3: speed-up 10,7,4,4
        cycle(1, 0, 2'b00, 2'b00, 0, 2'b00);
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        idle(2);
        cycle(0, 0, 2'b00, 2'b00, 1, 2'b00);
        wait_tick(sp); chk("sp_10", 32'(sp), 32'd10);
        cycle(0, 0, 2'b00, 2'b00, 1, 2'b00);
        wait_tick(sp); chk("sp_7", 32'(sp), 32'd7);
        cycle(0, 0, 2'b00, 2'b00, 1, 2'b00);
        wait_tick(sp); chk("sp_4a", 32'(sp), 32'd4);
        wait_tick(sp); chk("sp_4b", 32'(sp), 32'd4);

        // 4: P1 full queue, right pulse in the tick cycle
        cycle(1, 0, 2'b00, 2'b00, 0, 2'b00);
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        cycle(0, 0, 2'b00, 2'b10, 0, 2'b00);
        cycle(0, 0, 2'b00, 2'b10, 0, 2'b00);
        chk("full_noovf", 32'(overflow), 32'd0);
        idle(7);
        cycle(0, 0, 2'b00, 2'b10, 0, 2'b00);
        chk("pp_tick", 32'(tick), 32'd1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_dir1", 32'(dir[1]), 32'(UP));
        wait_tick(sp); chk("pp_next1", 32'(dir[1]), 32'(RIGHT));
        wait_tick(sp); chk("pp_next2", 32'(dir[1]), 32'(DOWN));
        wait_tick(sp); chk("pp_empty", 32'(dir[1]), 32'(DOWN));

        // 5: collision, OVER, back through MENU into a fresh game
        cycle(0, 0, 2'b00, 2'b00, 0, 2'b10);
        chk("col_mode", 32'(mode), 32'(OVER));
        chk("col_win", 32'(winner), 32'd1);
        t0 = n_ticks;
        idle(25);
        chk("over_ticks", 32'(n_ticks - t0), 32'd0);
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        chk("to_menu", 32'(mode), 32'(MENU));
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        chk("regame_dir1", 32'(dir[1]), 32'(LEFT));
        wait_tick(sp); chk("regame_sp", 32'(sp), 32'd10);

        // 6: rst mid-game with queued turns, then pulses in MENU
        cycle(0, 0, 2'b01, 2'b10, 0, 2'b00);
        cycle(1, 0, 2'b00, 2'b00, 0, 2'b00);
        chk("mrst_mode", 32'(mode), 32'(MENU));
        chk("mrst_win", 32'(winner), 32'd0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 2'(k), 2'(k + 1), k[0], 2'(k));
        chk("menu_mode", 32'(mode), 32'(MENU));
        chk("menu_ovf", 32'(overflow), 32'd0);
        cycle(0, 1, 2'b00, 2'b00, 0, 2'b00);
        wait_tick(sp);
        chk("fresh_dir0", 32'(dir[0]), 32'(RIGHT));
        chk("fresh_dir1", 32'(dir[1]), 32'(LEFT));

        // Randomized run against the model
        for (int k = 0; k < 4000; k++) begin
            rl = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            rr = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            rc = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(($urandom_range(0, 999) == 0), ($urandom_range(0, 29) == 0), rl, rr,
                  ($urandom_range(0, 19) == 0), rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
